// File: rtl/gpu_pkg.sv
// Shared constants, command codes, FSM state encodings and the latched draw
// command record for the GPU draw engine.
package gpu_pkg;

    localparam int FB_W     = 64;
    localparam int FB_H     = 32;
    localparam int FB_BYTES = FB_W * FB_H / 8;

    localparam logic [3:0] GPU_NOP   = 4'd0;
    localparam logic [3:0] GPU_CLEAR = 4'd1;
    localparam logic [3:0] GPU_DRAW  = 4'd2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_XOR_L = 3'd3;
    localparam logic [2:0] ST_XOR_R = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef struct packed {
        logic [11:0] offset;
        logic [5:0]  x;
        logic [4:0]  y;
        logic [3:0]  len;
    } draw_cmd_t;

endpackage

// File: rtl/gpu_framebuffer.sv
// 256x8 monochrome framebuffer: combinational-read/synchronous-write RMW port
// for the engine plus a registered read port for scan-out.
module gpu_framebuffer
    import gpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rmw_addr_i,
    output logic [7:0] rmw_rdata_o,
    input  logic       rmw_we_i,
    input  logic [7:0] rmw_wdata_i,
    input  logic [7:0] rd_addr_i,
    output logic [7:0] rd_data_o
);

    logic [7:0] mem_q [0:FB_BYTES-1];
    logic [7:0] rd_data_q;

    assign rmw_rdata_o = mem_q[rmw_addr_i];
    assign rd_data_o   = rd_data_q;

    // Storage is deliberately left out of reset so the picture survives it.
    always_ff @(posedge clk) begin
        if (rmw_we_i) begin
            mem_q[rmw_addr_i] <= rmw_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/gpu_draw_engine.sv
// CLEAR/DRAW command responder: fetches sprite rows from memory and XORs them
// into the framebuffer, reporting any pixel collision.
module gpu_draw_engine
    import gpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  gpu_cmd,
    input  logic [15:0] gpu_draw_offset,
    input  logic [7:0]  gpu_draw_x,
    input  logic [7:0]  gpu_draw_y,
    input  logic [7:0]  gpu_draw_length,
    input  logic        gpu_cmd_submitted,
    output logic        gpu_ready,
    output logic        gpu_collision,
    output logic        mem_read,
    output logic [11:0] mem_read_addr,
    input  logic [7:0]  mem_read_data,
    input  logic        mem_read_ack,
    input  logic [7:0]  fb_read_addr,
    output logic [7:0]  fb_read_data
);

    logic [2:0] state_q, state_d;
    draw_cmd_t  cmd_q, cmd_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] sprite_q, sprite_d;
    logic       coll_q, coll_d;

    logic [7:0] fb_addr, fb_rdata, fb_wdata, pattern;
    logic       fb_we;
    logic [5:0] row_y;
    logic [2:0] col_c, shift;
    logic       unused_bits;

    assign unused_bits = ^{gpu_draw_offset[15:12], gpu_draw_x[7:6],
                           gpu_draw_y[7:5], gpu_draw_length[7:4]};

    // Bit 5 of the row sum flags a row that fell off the bottom edge.
    assign row_y = {1'b0, cmd_q.y} + {2'b00, cnt_q[3:0]};
    assign col_c = cmd_q.x[5:3];
    assign shift = cmd_q.x[2:0];

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        sprite_d = sprite_q;
        coll_d   = coll_q;
        fb_we    = 1'b0;
        fb_addr  = {row_y[4:0], col_c};
        pattern  = 8'h00;
        fb_wdata = fb_rdata ^ pattern;
        case (state_q)
            ST_IDLE: begin
                if (gpu_cmd_submitted) begin
                    cmd_d.offset = gpu_draw_offset[11:0];
                    cmd_d.x      = gpu_draw_x[5:0];
                    cmd_d.y      = gpu_draw_y[4:0];
                    cmd_d.len    = gpu_draw_length[3:0];
                    cnt_d        = 8'h00;
                    coll_d       = 1'b0;
                    if (gpu_cmd == GPU_CLEAR) begin
                        state_d = ST_CLEAR;
                    end else if (gpu_cmd == GPU_DRAW && gpu_draw_length[3:0] != 4'd0) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CLEAR: begin
                fb_we    = 1'b1;
                fb_addr  = cnt_q;
                fb_wdata = 8'h00;
                cnt_d    = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_DONE;
                end
            end
            ST_FETCH: begin
                if (mem_read_ack) begin
                    sprite_d = mem_read_data;
                    state_d  = ST_XOR_L;
                end
            end
            ST_XOR_L: begin
                pattern  = sprite_q >> shift;
                fb_wdata = fb_rdata ^ pattern;
                fb_we    = !row_y[5];
                if (fb_we && (fb_rdata & pattern) != 8'h00) begin
                    coll_d = 1'b1;
                end
                state_d = ST_XOR_R;
            end
            ST_XOR_R: begin
                // Spill into the next byte; nothing wraps past column 63.
                pattern  = sprite_q << (4'd8 - {1'b0, shift});
                fb_addr  = {row_y[4:0], col_c + 3'd1};
                fb_wdata = fb_rdata ^ pattern;
                fb_we    = !row_y[5] && shift != 3'd0 && col_c != 3'd7;
                if (fb_we && (fb_rdata & pattern) != 8'h00) begin
                    coll_d = 1'b1;
                end
                cnt_d = cnt_q + 8'd1;
                if (cnt_d == {4'h0, cmd_q.len}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            cnt_q    <= 8'h00;
            sprite_q <= 8'h00;
            coll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            sprite_q <= sprite_d;
            coll_q   <= coll_d;
        end
    end

    assign gpu_ready     = (state_q == ST_IDLE);
    assign gpu_collision = coll_q;
    assign mem_read      = (state_q == ST_FETCH);
    assign mem_read_addr = cmd_q.offset + {4'h0, cnt_q};

    gpu_framebuffer u_fb (
        .clk         (clk),
        .reset       (reset),
        .rmw_addr_i  (fb_addr),
        .rmw_rdata_o (fb_rdata),
        .rmw_we_i    (fb_we),
        .rmw_wdata_i (fb_wdata),
        .rd_addr_i   (fb_read_addr),
        .rd_data_o   (fb_read_data)
    );

endmodule

// File: tb/tb_gpu_draw_engine.sv
// Directed bench for gpu_draw_engine with a behavioural framebuffer model,
// a delay-programmable memory responder and a per-cycle scan-out checker.
module tb_gpu_draw_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  gpu_cmd = 4'd0;
    logic [15:0] gpu_draw_offset = 16'h0;
    logic [7:0]  gpu_draw_x = 8'h0, gpu_draw_y = 8'h0, gpu_draw_length = 8'h0;
    logic        gpu_cmd_submitted = 1'b0;
    logic        gpu_ready, gpu_collision, mem_read;
    logic [11:0] mem_read_addr;
    logic [7:0]  mem_read_data = 8'h0;
    logic        ack_r = 1'b0, spurious = 1'b0;
    wire         mem_read_ack = ack_r | spurious;
    logic [7:0]  fb_read_addr = 8'h0;
    logic [7:0]  fb_read_data;

    gpu_draw_engine dut (
        .clk(clk), .reset(reset), .gpu_cmd(gpu_cmd), .gpu_draw_offset(gpu_draw_offset),
        .gpu_draw_x(gpu_draw_x), .gpu_draw_y(gpu_draw_y), .gpu_draw_length(gpu_draw_length),
        .gpu_cmd_submitted(gpu_cmd_submitted), .gpu_ready(gpu_ready),
        .gpu_collision(gpu_collision), .mem_read(mem_read), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
        .fb_read_addr(fb_read_addr), .fb_read_data(fb_read_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [0:4095];
    logic [7:0]  fb_model [0:255];
    logic [11:0] fetch_q [$];
    int          ack_delay = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay extra cycles, checks address stability.
    logic        held = 1'b0;
    logic [11:0] held_addr = 12'h0;
    int          wcnt = 0;
    always @(posedge clk) begin
        #1;
        ack_r = 1'b0;
        if (!mem_read || reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("addr_stable", int'(mem_read_addr), int'(held_addr));
            end else begin
                held = 1'b1;
                held_addr = mem_read_addr;
                wcnt = 0;
                fetch_q.push_back(mem_read_addr);
            end
            if (wcnt == ack_delay) begin
                ack_r = 1'b1;
                mem_read_data = mem[mem_read_addr];
                held = 1'b0;
            end else begin
                wcnt++;
            end
        end
    end

    // Scan-out compare: each cycle a scan is active, the registered byte must match the model.
    logic       scan_chk = 1'b0;
    logic [7:0] scan_chk_addr = 8'h0;
    always @(negedge clk) begin
        if (scan_chk) chk("fb_scan", int'(fb_read_data), int'(fb_model[scan_chk_addr]));
    end

    task automatic scan_fb();
        for (int a = 0; a < 256; a++) begin
            @(posedge clk); #1;
            scan_chk = (a > 0);
            scan_chk_addr = 8'(a - 1);
            fb_read_addr = 8'(a);
        end
        @(posedge clk); #1;
        scan_chk = 1'b1;
        scan_chk_addr = 8'hFF;
        @(posedge clk); #1;
        scan_chk = 1'b0;
    endtask

    task automatic read_fb(input int a, input int exp, input string name);
        @(posedge clk); #1 fb_read_addr = 8'(a);
        @(posedge clk); #1 chk(name, int'(fb_read_data), exp);
    endtask

    // Sprite row as a 16-bit window so the left/right bytes fall out of one shift.
    function automatic bit model_draw(input int off, input int x, input int y, input int len);
        bit coll = 0;
        int xx = x % 64;
        int c = xx / 8;
        for (int r = 0; r < (len % 16); r++) begin
            int yy = (y % 32) + r;
            logic [15:0] win = {mem[(off + r) % 4096], 8'h00} >> (xx % 8);
            if (yy >= 32) continue;
            if ((fb_model[yy*8 + c] & win[15:8]) != 0) coll = 1;
            fb_model[yy*8 + c] ^= win[15:8];
            if (c < 7) begin
                if ((fb_model[yy*8 + c + 1] & win[7:0]) != 0) coll = 1;
                fb_model[yy*8 + c + 1] ^= win[7:0];
            end
        end
        return coll;
    endfunction

    task automatic run_cmd(input logic [3:0] cmd, input int off, input int x, input int y,
                           input int len, input bit poke, input string name);
        int n;
        int exp_lat;
        bit exp_coll = 0;
        exp_lat = 2;
        if (cmd == 4'd1) begin
            exp_lat = 258;
            for (int i = 0; i < 256; i++) fb_model[i] = 8'h00;
        end else if (cmd == 4'd2) begin
            exp_lat = (len % 16) * (ack_delay + 3) + 2;
            exp_coll = model_draw(off, x, y, len);
        end
        fetch_q.delete();
        @(posedge clk); #1;
        gpu_cmd = cmd; gpu_draw_offset = 16'(off); gpu_draw_x = 8'(x);
        gpu_draw_y = 8'(y); gpu_draw_length = 8'(len); gpu_cmd_submitted = 1'b1;
        @(posedge clk); #1;
        gpu_cmd_submitted = 1'b0;
        chk({name, "_busy"}, int'(gpu_ready), 0);
        n = 1;
        while (!gpu_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 2) begin
                gpu_cmd = 4'd1; gpu_cmd_submitted = 1'b1;
            end else begin
                gpu_cmd_submitted = 1'b0;
            end
        end
        gpu_cmd_submitted = 1'b0;
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_collision"}, int'(gpu_collision), int'(exp_coll));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7 + 3) ^ 8'h5A);
        mem[12'h200] = 8'hF0;
        mem[12'h300] = 8'hFF;
        for (int i = 0; i < 4; i++) mem[12'h310 + i] = 8'hFF;
        mem[12'h320] = 8'hA5;
        mem[12'hFFF] = 8'h81;
        mem[12'h000] = 8'h3C;
        mem[12'h330] = 8'hC3;
        mem[12'h340] = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(gpu_ready), 1);
        chk("rst_collision", int'(gpu_collision), 0);
        chk("rst_mem_read", int'(mem_read), 0);
        chk("rst_mem_addr", int'(mem_read_addr), 0);
        chk("rst_fb_data", int'(fb_read_data), 0);
        reset = 1'b0;

        run_cmd(4'd1, 0, 0, 0, 0, 0, "clear");
        scan_fb();

        run_cmd(4'd2, 16'h0200, 0, 0, 1, 0, "draw00");
        read_fb(0, 8'hF0, "draw00_byte");
        chk("draw00_coll_lit", int'(gpu_collision), 0);
        run_cmd(4'd2, 16'h0200, 0, 0, 1, 0, "redraw00");
        read_fb(0, 8'h00, "redraw00_byte");
        chk("redraw00_coll_lit", int'(gpu_collision), 1);

        run_cmd(4'd2, 16'h0300, 5, 3, 1, 0, "draw53");
        read_fb(24, 8'h07, "draw53_left");
        read_fb(25, 8'hF8, "draw53_right");

        run_cmd(4'd2, 16'h0310, 62, 30, 4, 0, "clip");
        chk("clip_fetches", fetch_q.size(), 4);
        read_fb(247, 8'h03, "clip_row30");
        read_fb(255, 8'h03, "clip_row31");
        read_fb(7, 8'h00, "clip_row0");
        read_fb(15, 8'h00, "clip_row1");
        scan_fb();

        run_cmd(4'd2, 16'h0320, 72, 32, 1, 0, "wrapxy");
        read_fb(1, 8'hA5, "wrapxy_byte");

        run_cmd(4'd2, 16'hFFFF, 16, 10, 2, 0, "wrapaddr");
        chk("wrapaddr_n", fetch_q.size(), 2);
        if (fetch_q.size() == 2) begin
            chk("wrapaddr_a0", int'(fetch_q[0]), 12'hFFF);
            chk("wrapaddr_a1", int'(fetch_q[1]), 12'h000);
        end

        ack_delay = 5;
        run_cmd(4'd2, 16'h0330, 3, 20, 1, 1, "slowack");
        scan_fb();

        // Abort a DRAW while its first fetch is still outstanding.
        @(posedge clk); #1;
        gpu_cmd = 4'd2; gpu_draw_offset = 16'h0340; gpu_draw_x = 8'd0;
        gpu_draw_y = 8'd5; gpu_draw_length = 8'd3; gpu_cmd_submitted = 1'b1;
        @(posedge clk); #1 gpu_cmd_submitted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_fetching", int'(mem_read), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", int'(gpu_ready), 1);
        chk("abort_mem_read", int'(mem_read), 0);
        chk("abort_collision", int'(gpu_collision), 0);
        spurious = 1'b1;
        @(posedge clk); #1;
        spurious = 1'b0;
        chk("abort_ack_ignored_ready", int'(gpu_ready), 1);
        chk("abort_ack_ignored_rd", int'(mem_read), 0);
        ack_delay = 0;

        run_cmd(4'd0, 0, 0, 0, 0, 0, "nop");
        run_cmd(4'd7, 0, 0, 0, 0, 0, "unknown");
        run_cmd(4'd2, 16'h0200, 0, 0, 16, 0, "len0");
        run_cmd(4'd2, 16'h0330, 9, 31, 8'h12, 0, "lenmask");
        scan_fb();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/gpu_draw_engine.md
# gpu_draw_engine

Responder side of the CPU→GPU command handshake: accepts CLEAR and DRAW commands, fetches sprite bytes over the shared memory read interface, XORs them into a 64×32 monochrome framebuffer, and reports pixel collision back to the CPU. Sits between the CPU's GPU command port and the memory read port. Exposes a byte-wide read port for the display scan-out logic.

## Interface
- FB_W, 64, framebuffer width in pixels (fixed; multiple of 8)
- FB_H, 32, framebuffer height in pixels (fixed)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- gpu_cmd  in  4  command code: 0 NOP, 1 CLEAR, 2 DRAW, others NOP
- gpu_draw_offset  in  16  sprite base address; low 12 bits used
- gpu_draw_x  in  8  sprite X; taken mod 64
- gpu_draw_y  in  8  sprite Y; taken mod 32
- gpu_draw_length  in  8  sprite rows; low 4 bits used (0–15)
- gpu_cmd_submitted  in  1  one-cycle command strobe
- gpu_ready  out  1  idle and able to accept a command
- gpu_collision  out  1  result of last completed DRAW
- mem_read  out  1  memory read request
- mem_read_addr  out  12  memory read address
- mem_read_data  in  8  memory read data, valid with ack
- mem_read_ack  in  1  memory read acknowledge
- fb_read_addr  in  8  display read address {row[4:0], col[2:0]}
- fb_read_data  out  8  framebuffer byte, MSB = leftmost pixel

## Operation
- Framebuffer: 256 bytes, row-major, 8 bytes per row. Not altered by reset.
- States: IDLE, CLEAR, FETCH, XOR_L, XOR_R, DONE.
- IDLE: gpu_ready=1. On gpu_cmd_submitted, latch all command fields, clear gpu_collision, go to CLEAR (cmd 1), FETCH (cmd 2, length≠0), or DONE (NOP/unknown, or DRAW with length 0).
- CLEAR: write 0 to byte index 0..255, one per cycle, then DONE.
- FETCH: mem_read=1, mem_read_addr=(offset+r) mod 4096, held stable until the cycle mem_read_ack=1; latch mem_read_data, go XOR_L. mem_read drops the cycle after ack.
- Row address: y=(draw_y mod 32)+r; if y>31 row is clipped (no writes, no collision, fetch still performed).
- Column: x=draw_x mod 64, c=x[5:3], s=x[2:0].
- XOR_L: pattern = sprite>>s into byte (y,c).
- XOR_R: if s≠0 and c<7, pattern = sprite<<(8−s) into byte (y,c+1); else no write (pixels right of column 63 clipped, no horizontal wrap).
- Each write: new = old ^ pattern; gpu_collision set if (old & pattern)≠0. Sticky until next accepted command.
- After XOR_R: r++; r==length → DONE else FETCH.
- DONE: one cycle, then IDLE.
- gpu_cmd_submitted while gpu_ready=0: ignored.
- Reset mid-command: next cycle IDLE, gpu_ready=1, mem_read=0, gpu_collision=0; partial framebuffer writes persist; any outstanding ack after reset ignored.

## Timing
- Reset values: gpu_ready=1, gpu_collision=0, mem_read=0, mem_read_addr=0, fb_read_data=0.
- Accept at cycle T → gpu_ready=0 at T+1.
- NOP: ready returns at T+2.
- CLEAR: writes T+1..T+256, DONE T+257, ready=1 at T+258.
- DRAW: per row = (cycles until ack, ≥1) + 2; plus 1 DONE cycle. With single-cycle ack, N rows: ready=1 at T+3N+2.
- gpu_collision valid when gpu_ready rises after DRAW.
- fb_read_data: registered, 1-cycle latency; same-cycle write not visible (old data returned).

## Structure
- gpu_pkg: command codes (GPU_NOP, GPU_CLEAR, GPU_DRAW), FB_W/FB_H, state enum.
- Sub-module gpu_framebuffer: 256×8 storage with one combinational-read/synchronous-write RMW port and one registered read port.
- gpu_draw_engine: FSM, row counter, address generation, shift/XOR/collision logic.

## Test plan
- Reset, CLEAR → all 256 bytes 0x00 via fb_read port; ready low exactly 257 cycles.
- DRAW x=0,y=0,len=1, mem[0x200]=0xF0 → byte(0,0)=0xF0, collision=0; repeat → 0x00, collision=1.
- DRAW x=5,y=3,len=1, sprite 0xFF → byte(3,0)=0x07, byte(3,1)=0xF8.
- DRAW x=62,y=30,len=4, sprite 0xFF each → rows 30,31 byte 7 = 0x03; rows 0,1 untouched; 4 fetches issued.
- DRAW x=64+8,y=32 (wrap) len=1 → lands at byte(0,1); offset 0xFFF, len 2 → addresses 0xFFF, 0x000.
- Ack delayed 5 cycles, mem_read_addr stable throughout; reset asserted mid-DRAW → ready=1, mem_read=0 next cycle; submit while busy ignored.
